// File: rtl/smips_multicycle.sv
// Multicycle SMIPS subset core: FETCH -> DECODE -> EXEC -> WB, with a sticky HALT.
// Supports ADD/SUB/AND/OR/SLT (R-type), ADDI, BEQ and HALT; any other encoding halts the core.
//
// state  | meaning
// FETCH  | request instruction at pc, latch it into IR on imem_ack
// DECODE | read operands A/B, detect HALT or illegal encodings
// EXEC   | compute ALU result, branch condition and branch target
// WB     | write the destination register, advance pc, count the retirement
// HALT   | core stopped until reset
module smips_multicycle #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     pc,
  output logic            halted,
  output logic [31:0]     retired,
  output logic            wb_en,
  output logic [4:0]      wb_reg,
  output logic [XLEN-1:0] wb_data
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, retired_q, ir_q, target_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic            taken_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [5:0]      opcode, funct;
  logic [IDXW-1:0] rs_idx, rt_idx, dst_idx;
  logic [4:0]      dst_field;
  logic            is_alu_r, is_addi, is_beq, is_halt, is_legal, is_write;
  logic [XLEN-1:0] imm_sext, alu_res;
  logic [31:0]     br_off;
  logic            unused_ir;

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs_idx    = ir_q[21 +: IDXW];
  assign rt_idx    = ir_q[16 +: IDXW];
  assign is_alu_r  = (opcode == OP_RTYPE) &&
                     (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                      funct == FN_OR  || funct == FN_SLT);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_halt   = (opcode == OP_HALT);
  assign is_legal  = is_alu_r || is_addi || is_beq || is_halt;
  assign is_write  = is_alu_r || is_addi;
  // wb_reg reports the architectural 5-bit field; only its low bits select a physical register
  assign dst_field = is_addi ? ir_q[20:16] : ir_q[15:11];
  assign dst_idx   = dst_field[IDXW-1:0];
  assign imm_sext  = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign br_off    = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  // shamt and the high register-field bits (small NREGS) carry no meaning here
  assign unused_ir = ^{ir_q[10:6], ir_q[25:21], ir_q[20:16]};

  // ALU result for the instruction held in IR
  always_comb begin
    alu_res = '0;
    if (is_addi) begin
      alu_res = a_q + imm_sext;
    end else begin
      case (funct)
        FN_ADD:  alu_res = a_q + b_q;
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        default: alu_res = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (imem_ack) state_d = DECODE;
      DECODE:  state_d = (is_halt || !is_legal) ? HALT : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Datapath registers: IR, operands, result, branch info, pc and retirement count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      taken_q   <= 1'b0;
      target_q  <= '0;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          a_q <= (rs_idx == '0) ? '0 : rf_q[rs_idx];
          b_q <= (rt_idx == '0) ? '0 : rf_q[rt_idx];
          // HALT retires in place; illegal encodings stop without retiring
          if (is_halt) retired_q <= retired_q + 32'd1;
        end
        EXEC: begin
          res_q    <= alu_res;
          taken_q  <= is_beq && (a_q == b_q);
          target_q <= pc_q + 32'd4 + br_off;
        end
        WB: begin
          pc_q      <= taken_q ? target_q : pc_q + 32'd4;
          retired_q <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Register file write port; contents are not reset
  always_ff @(posedge clk) begin
    if (wb_en) rf_q[dst_idx] <= res_q;
  end

  assign wb_en     = (state_q == WB) && is_write && (dst_idx != '0);
  assign wb_reg    = dst_field;
  assign wb_data   = res_q;
  assign imem_req  = (state_q == FETCH) && !rst;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == HALT);
  assign retired   = retired_q;

endmodule

// File: tb/tb_smips_multicycle.sv
// Bench: two cores (NREGS=32 and NREGS=8) run the same instruction stream in lockstep,
// each checked against its own instruction-level reference model.
module tb_smips_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic [1:0]       req_w, halted_w, wb_en_w;
  logic [1:0][31:0] addr_w, pc_w, retired_w, wb_data_w;
  logic [1:0][4:0]  wb_reg_w;

  int n_vec = 0;
  int n_err = 0;

  int          nr [2] = '{32, 8};
  logic [31:0] mpc [2];
  logic [31:0] mret [2];
  logic [31:0] mrf [2][32];

  always #5 clk = ~clk;

  smips_multicycle u_dut32 (
    .clk(clk), .rst(rst),
    .imem_req(req_w[0]), .imem_addr(addr_w[0]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc_w[0]), .halted(halted_w[0]), .retired(retired_w[0]),
    .wb_en(wb_en_w[0]), .wb_reg(wb_reg_w[0]), .wb_data(wb_data_w[0])
  );

  smips_multicycle #(.NREGS(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .imem_req(req_w[1]), .imem_addr(addr_w[1]),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc_w[1]), .halted(halted_w[1]), .retired(retired_w[1]),
    .wb_en(wb_en_w[1]), .wb_reg(wb_reg_w[1]), .wb_data(wb_data_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // registers whose low 3 bits are zero (other than r0) would alias r0 in the 8-entry core
  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    while (r != 0 && r[2:0] == 3'd0) r = 5'($urandom_range(1, 31));
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpc[k]  = 32'h0;
      mret[k] = 32'h0;
      for (int i = 0; i < 32; i++) mrf[k][i] = 32'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_req"}, 32'(req_w[k]), 32'h0);
      chk({tag, "_pc"}, pc_w[k], 32'h0);
      chk({tag, "_retired"}, retired_w[k], 32'h0);
      chk({tag, "_halted"}, 32'(halted_w[k]), 32'h0);
      chk({tag, "_wb_en"}, 32'(wb_en_w[k]), 32'h0);
    end
  endtask

  // asynchronous reset asserted between clock edges, released on a falling edge
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1 model_reset();
  endtask

  // Run one instruction through both cores; called with the cores sitting in a fetch cycle.
  task automatic do_instr(input logic [31:0] ins, input int waits);
    logic [5:0]  op, fn;
    int          rs, rt, rd, dst, cycles, phys;
    logic [31:0] a, b, res, simm;
    bit          legal, is_halt, runs;
    logic [31:0] exp_pc [2];
    logic [31:0] exp_ret [2];
    logic [31:0] exp_data [2];
    bit          exp_wb [2];
    logic [4:0]  exp_reg;
    int          wbn [2];
    logic [4:0]  got_reg [2];
    logic [31:0] got_data [2];

    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    simm = 32'($signed(ins[15:0]));
    legal = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A))
            || op == 6'h04 || op == 6'h08 || op == 6'h3F;
    is_halt = (op == 6'h3F);
    runs = legal && !is_halt;
    exp_reg = 5'h0;

    for (int k = 0; k < 2; k++) begin
      a = mrf[k][rs % nr[k]];
      b = mrf[k][rt % nr[k]];
      res = 32'h0;
      exp_wb[k] = 1'b0; exp_data[k] = 32'h0;
      exp_pc[k] = mpc[k]; exp_ret[k] = mret[k];
      if (runs) begin
        exp_ret[k] = mret[k] + 1;
        exp_pc[k] = mpc[k] + 4;
        dst = -1;
        if (op == 6'h00) begin
          dst = rd;
          case (fn)
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          endcase
        end else if (op == 6'h08) begin
          dst = rt;
          res = a + simm;
        end else if (a == b) begin
          exp_pc[k] = mpc[k] + 4 + simm * 4;
        end
        if (dst >= 0) begin
          exp_reg = 5'(dst);
          phys = dst % nr[k];
          if (phys != 0) begin
            exp_wb[k] = 1'b1;
            exp_data[k] = res;
            mrf[k][phys] = res;
          end
        end
      end else if (is_halt) begin
        exp_ret[k] = mret[k] + 1;
      end
    end

    for (int k = 0; k < 2; k++) begin
      chk("fetch_req", 32'(req_w[k]), 32'h1);
      chk("fetch_addr", addr_w[k], mpc[k]);
    end
    for (int w = 0; w < waits; w++) begin
      imem_ack = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("wait_req", 32'(req_w[k]), 32'h1);
        chk("wait_addr", addr_w[k], mpc[k]);
      end
    end
    imem_ack = 1'b1; imem_rdata = ins;
    @(posedge clk); #1;
    imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;

    cycles = 0;
    wbn = '{0, 0};
    got_reg = '{5'h0, 5'h0};
    got_data = '{32'h0, 32'h0};
    while (cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
      for (int k = 0; k < 2; k++) begin
        if (wb_en_w[k]) begin
          wbn[k]++;
          got_reg[k] = wb_reg_w[k];
          got_data[k] = wb_data_w[k];
        end
      end
      if (req_w[0] || halted_w[0]) break;
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
    end
    imem_ack = 1'b0;

    chk("latency", 32'(cycles), runs ? 32'd3 : 32'd1);
    for (int k = 0; k < 2; k++) begin
      chk("wb_count", 32'(wbn[k]), 32'(exp_wb[k]));
      if (exp_wb[k]) begin
        chk("wb_reg", 32'(got_reg[k]), 32'(exp_reg));
        chk("wb_data", got_data[k], exp_data[k]);
      end
      chk("retired", retired_w[k], exp_ret[k]);
      chk("halted", 32'(halted_w[k]), runs ? 32'h0 : 32'h1);
      chk("pc", pc_w[k], exp_pc[k]);
      mpc[k] = exp_pc[k];
      mret[k] = exp_ret[k];
    end
  endtask

  task automatic halt_idle(input int n);
    repeat (n) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("halt_req", 32'(req_w[k]), 32'h0);
        chk("halt_halted", 32'(halted_w[k]), 32'h1);
        chk("halt_wb_en", 32'(wb_en_w[k]), 32'h0);
        chk("halt_retired", retired_w[k], mret[k]);
        chk("halt_pc", pc_w[k], mpc[k]);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic init_regs();
    for (int i = 1; i < 32; i++)
      if (i % 8 != 0) do_instr(itype(6'h08, 5'(i), 5'd0, 16'($urandom)), $urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    int          wb_cycles;

    model_reset();
    #1 check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // ADDI r1,r0,5 ; ADDI r2,r0,-3 ; ADD r3,r1,r2
    do_instr(itype(6'h08, 5'd1, 5'd0, 16'd5), 0);
    do_instr(itype(6'h08, 5'd2, 5'd0, 16'hFFFD), 0);
    do_instr(rtype(6'h20, 5'd3, 5'd1, 5'd2), 0);
    chk("seq_retired", retired_w[0], 32'd3);
    // SLT r4,r2,r1 at 0x0C, then BEQ r0,r0,-1 at 0x10 loops back onto itself
    do_instr(rtype(6'h2A, 5'd4, 5'd2, 5'd1), 0);
    do_instr(itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 0);
    chk("beq_self", addr_w[0], 32'h10);
    do_instr(rtype(6'h22, 5'd5, 5'd1, 5'd1), 0);
    do_instr(itype(6'h08, 5'd6, 5'd0, 16'h7878), 0);
    do_instr(rtype(6'h20, 5'd6, 5'd6, 5'd6), 0);
    do_instr(itype(6'h08, 5'd7, 5'd0, 16'h0FF0), 0);
    do_instr(itype(6'h04, 5'd0, 5'd1, 16'd2), 0);
    chk("beq_not_taken", addr_w[0], 32'h24);
    do_instr(rtype(6'h24, 5'd9, 5'd6, 5'd7), 0);
    do_instr(rtype(6'h25, 5'd10, 5'd6, 5'd7), 0);
    // three fetch wait cycles
    do_instr(itype(6'h08, 5'd11, 5'd0, 16'd1), 3);
    // write to r0 is dropped but retires
    do_instr(itype(6'h08, 5'd0, 5'd0, 16'd7), 1);
    // HALT opcode retires and stops
    do_instr(itype(6'h3F, 5'd0, 5'd0, 16'd0), 0);
    halt_idle(5);
    apply_reset("rst_halted");

    // illegal opcode stops without retiring
    do_instr(itype(6'h08, 5'd1, 5'd0, 16'd3), 0);
    do_instr(itype(6'h23, 5'd1, 5'd0, 16'd0), 0);
    halt_idle(4);
    apply_reset("rst_illegal");

    // reset in the middle of a stalled fetch
    do_instr(itype(6'h08, 5'd1, 5'd0, 16'd4), 0);
    imem_ack = 1'b0;
    @(posedge clk); #1;
    apply_reset("rst_mid_fetch");

    // reset while a write-back is on the outputs
    do_instr(itype(6'h08, 5'd1, 5'd0, 16'd4), 0);
    imem_ack = 1'b1; imem_rdata = itype(6'h08, 5'd5, 5'd0, 16'd9);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    wb_cycles = 0;
    while (wb_cycles < 6 && !wb_en_w[0]) begin
      @(posedge clk); #1;
      wb_cycles++;
    end
    chk("wb_reached", 32'(wb_en_w[0]), 32'h1);
    apply_reset("rst_mid_wb");

    // r9 aliases physical r1 in the 8-register core
    do_instr(itype(6'h08, 5'd1, 5'd0, 16'd4), 0);
    do_instr(itype(6'h08, 5'd9, 5'd0, 16'd1), 0);
    do_instr(rtype(6'h20, 5'd2, 5'd1, 5'd0), 0);

    // randomized program
    init_regs();
    for (int n = 0; n < 200; n++) begin
      logic [4:0] ra, rb, rc;
      ra = pick_reg(); rb = pick_reg(); rc = pick_reg();
      case ($urandom_range(0, 6))
        0: ins = rtype(6'h20, rc, ra, rb);
        1: ins = rtype(6'h22, rc, ra, rb);
        2: ins = rtype(6'h24, rc, ra, rb);
        3: ins = rtype(6'h25, rc, ra, rb);
        4: ins = rtype(6'h2A, rc, ra, rb);
        5: ins = itype(6'h08, rc, ra, 16'($urandom));
        default: ins = itype(6'h04, ($urandom_range(0, 1) == 1) ? ra : rb, ra, 16'($urandom));
      endcase
      do_instr(ins, $urandom_range(0, 3));
    end
    op = 6'($urandom_range(0, 63));
    while (op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h3F) op = 6'($urandom_range(0, 63));
    do_instr({op, 26'($urandom)}, 1);
    halt_idle(3);
    apply_reset("rst_final");
    do_instr(rtype(6'h21, 5'd3, 5'd0, 5'd0), 0);
    halt_idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
